keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
Scans a 4x4 active-low matrix keypad, debounces one key at a time, and presents a held 4-bit key code plus a one-cycle strobe. This block is the producer feeding the password/entry register's 4-bit key-data input. Key 15 (row 3, column 3) is the "enter" key by convention downstream. The downstream register reacts to a change in the code, so pressing the same key twice gives no change there. Consumers that need every press use key_valid.

Parameters:
SCAN_DIV, 50000, CLK cycles per column slot; one scan tick is issued per slot (1 ms at 50 MHz).
DEBOUNCE_TICKS, 10, consecutive agreeing ticks needed to confirm a press or a release; legal range 1..255.

Ports:
CLK  input  1  system clock; all logic is on the rising edge.
RST  input  1  synchronous, active-high reset.
row  input  4  keypad row lines, active low, externally pulled up; asynchronous to CLK.
col  output 4  keypad column drive, one-hot active low.
key_code  output 4  last confirmed key = row_idx*4 + col_idx; held until the next confirmed press.
key_valid  output 1  one-cycle pulse when key_code is loaded (fires even if the value is unchanged).
key_down  output 1  high from press confirmation until release confirmation.

Behaviour:
- Reset (RST=1 at a CLK edge, wins over everything else):
  - col=4'b1110, col_idx=0, key_code=0, key_valid=0, key_down=0.
  - Divider=0, debounce count=0, state=SCAN, synchroniser flops=4'hF.
  - Applies mid-press too: nothing is emitted for an in-flight key, and scanning restarts at column 0.
- row passes through a 2-flop synchroniser; only sync_row is used below.
- Divider:
  - Counts 0..SCAN_DIV-1 and wraps.
  - tick=1 for exactly the cycle in which count==SCAN_DIV-1.
  - All state actions below happen only on tick cycles, except the key_valid clear.
- col always equals ~(1<<col_idx), so sampling at the end of a slot gives a full slot of settling.
- SCAN:
  - On tick with sync_row==4'hF: col_idx<=col_idx+1 (3 wraps to 0).
  - On tick with any row low:
    - Capture cand_col=col_idx and cand_row=lowest-index low row.
    - cnt<=1, col_idx holds, go DEBOUNCE.
    - If DEBOUNCE_TICKS==1, confirm immediately instead (same actions as confirm below).
- DEBOUNCE:
  - On tick with sync_row[cand_row]==0: cnt<=cnt+1.
  - When cnt+1==DEBOUNCE_TICKS, confirm:
    - key_code<=cand_row*4+cand_col, key_valid<=1, key_down<=1.
    - go HELD.
  - On tick with sync_row[cand_row]==1 (bounce): cnt<=0, col_idx<=col_idx+1, go SCAN; no output change.
- HELD:
  - col_idx stays frozen on cand_col.
  - On tick with sync_row[cand_row]==1: cnt<=1, go RELEASE.
  - Otherwise stay.
- RELEASE:
  - On tick with the row bit high: cnt<=cnt+1.
  - When cnt+1==DEBOUNCE_TICKS (immediately if DEBOUNCE_TICKS==1):
    - key_down<=0, col_idx<=col_idx+1, go SCAN.
  - On tick with the row bit low: go HELD, cnt<=0.
- key_valid: cleared on the cycle after it is set; never high for 2 consecutive cycles.
- Press latency: confirmation occurs on the (DEBOUNCE_TICKS-1)-th tick after the detection tick. key_code and key_valid update at that edge.
- Multiple keys:
  - In the scanned column, the lowest row index wins.
  - Other keys, including those in other columns, are ignored until the candidate is released.
  - A second key pressed while HELD produces nothing.
- cnt is 8 bits and saturates only via the state transitions above; it never wraps.

Test Plan:
(Sim parameters: SCAN_DIV=4, DEBOUNCE_TICKS=3.)
1. Reset released, no key pressed -> col cycles 1110,1101,1011,0111,1110, advancing every 4 CLKs; key_valid stays 0; key_code=0.
2. Hold row[1] low while col=1011, steady -> key_code=6 and key_valid pulses exactly 1 cycle, 2 ticks after detection; key_down=1; col stays 1011 while held.
3. Release the key from scenario 2 -> key_down falls after 3 high ticks; scanning resumes at col=0111; no key_valid.
4. Press row[3]/col[3] (code 15) twice, each with a clean release -> two key_valid pulses; key_code=15 both times.
5. Bounce: row low for 1 tick, then high -> no key_valid; key_code unchanged; state back to SCAN at the next column.
6. rows 0 and 2 both low in col 1; separately, assert RST while HELD -> first case gives key_code=1; after RST, key_code=0, key_down=0, col=1110 on the next cycle.

Source files
------------

// File: rtl/keypad_scanner_if.sv
// Keypad matrix lines plus the debounced key-event bus, bundled for the scanner and its consumer.
interface keypad_scanner_if;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_down;

  modport master (
    input  row,
    output col,
    output key_code,
    output key_valid,
    output key_down
  );

  modport slave (
    output row,
    input  col,
    input  key_code,
    input  key_valid,
    input  key_down
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner: column drive, row synchroniser, single-key debounce,
// held key code with a one-cycle strobe on each confirmed press.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned DEBOUNCE_TICKS = 10
) (
  input logic          CLK,
  input logic          RST,
  keypad_scanner_if.master kp
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    S_SCAN     = 2'd0,
    S_DEBOUNCE = 2'd1,
    S_HELD     = 2'd2,
    S_RELEASE  = 2'd3
  } state_t;

  state_t             state;
  logic [DIV_W-1:0]   div_cnt;
  logic [CNT_W-1:0]   cnt;
  logic [3:0]         sync1;
  logic [3:0]         sync_row;
  logic [1:0]         col_idx;
  logic [1:0]         cand_row;
  logic [1:0]         cand_col;

  logic               tick;
  logic [1:0]         idx_inc;
  logic [3:0]         col_inc;
  logic [CNT_W-1:0]   cnt_inc;
  logic               cnt_done;
  logic               cand_high;

  // Lowest-index active (low) row; only meaningful when at least one row is low.
  function automatic logic [1:0] lowest_low(input logic [3:0] r);
    if (!r[0])      lowest_low = 2'd0;
    else if (!r[1]) lowest_low = 2'd1;
    else if (!r[2]) lowest_low = 2'd2;
    else            lowest_low = 2'd3;
  endfunction

  always_comb begin
    tick      = (div_cnt == DIV_W'(SCAN_DIV - 1));
    idx_inc   = col_idx + 2'd1;
    col_inc   = ~(4'b0001 << idx_inc);
    cnt_inc   = cnt + CNT_W'(1);
    cnt_done  = (cnt_inc == CNT_W'(DEBOUNCE_TICKS));
    cand_high = sync_row[cand_row];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= S_SCAN;
      div_cnt      <= '0;
      cnt          <= '0;
      sync1        <= 4'hF;
      sync_row     <= 4'hF;
      col_idx      <= 2'd0;
      cand_row     <= 2'd0;
      cand_col     <= 2'd0;
      kp.col       <= 4'b1110;
      kp.key_code  <= 4'd0;
      kp.key_valid <= 1'b0;
      kp.key_down  <= 1'b0;
    end else begin
      sync1        <= kp.row;
      sync_row     <= sync1;
      kp.key_valid <= 1'b0;
      div_cnt      <= tick ? '0 : div_cnt + DIV_W'(1);

      if (tick) begin
        case (state)
          S_SCAN: begin
            if (sync_row == 4'hF) begin
              col_idx <= idx_inc;
              kp.col  <= col_inc;
            end else begin
              cand_row <= lowest_low(sync_row);
              cand_col <= col_idx;
              if (DEBOUNCE_TICKS == 1) begin
                cnt          <= CNT_W'(1);
                kp.key_code  <= {lowest_low(sync_row), col_idx};
                kp.key_valid <= 1'b1;
                kp.key_down  <= 1'b1;
                state        <= S_HELD;
              end else begin
                cnt   <= CNT_W'(1);
                state <= S_DEBOUNCE;
              end
            end
          end

          S_DEBOUNCE: begin
            if (!cand_high) begin
              cnt <= cnt_inc;
              if (cnt_done) begin
                kp.key_code  <= {cand_row, cand_col};
                kp.key_valid <= 1'b1;
                kp.key_down  <= 1'b1;
                state        <= S_HELD;
              end
            end else begin
              // Bounce: abandon the candidate and move on to the next column.
              cnt     <= '0;
              col_idx <= idx_inc;
              kp.col  <= col_inc;
              state   <= S_SCAN;
            end
          end

          S_HELD: begin
            if (cand_high) begin
              if (DEBOUNCE_TICKS == 1) begin
                cnt         <= '0;
                kp.key_down <= 1'b0;
                col_idx     <= idx_inc;
                kp.col      <= col_inc;
                state       <= S_SCAN;
              end else begin
                cnt   <= CNT_W'(1);
                state <= S_RELEASE;
              end
            end
          end

          S_RELEASE: begin
            if (cand_high) begin
              if (cnt_done) begin
                cnt         <= '0;
                kp.key_down <= 1'b0;
                col_idx     <= idx_inc;
                kp.col      <= col_inc;
                state       <= S_SCAN;
              end else begin
                cnt <= cnt_inc;
              end
            end else begin
              cnt   <= '0;
              state <= S_HELD;
            end
          end

          default: state <= S_SCAN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Keypad scanner bench: physical keypad model driving rows from the DUT columns, tick-level reference model.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DT       = 3;

  localparam int M_SCAN = 0;
  localparam int M_DEB  = 1;
  localparam int M_HELD = 2;
  localparam int M_REL  = 3;

  logic        CLK;
  logic        RST;
  logic [15:0] mask;

  int vectors;
  int errors;
  int pulses;

  int m_div, m_mode, m_idx, m_crow, m_ccol, m_cnt, m_code;
  bit m_valid, m_down;

  keypad_scanner_if kp ();

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_TICKS(DT)) dut (
    .CLK (CLK),
    .RST (RST),
    .kp  (kp)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Physical keypad: a pressed key shorts its row to its column line.
  function automatic logic [3:0] pad_rows(input logic [15:0] m, input logic [3:0] c);
    logic [3:0] r;
    r = 4'hF;
    for (int ri = 0; ri < 4; ri++)
      for (int ci = 0; ci < 4; ci++)
        if (c[ci] === 1'b0 && m[ri*4+ci]) r[ri] = 1'b0;
    return r;
  endfunction

  always_comb kp.row = pad_rows(mask, kp.col);

  function automatic logic [3:0] rows_seen(input logic [15:0] m, input int idx);
    logic [3:0] r;
    r = 4'hF;
    for (int ri = 0; ri < 4; ri++)
      if (m[ri*4+idx]) r[ri] = 1'b0;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic confirm_press();
    m_code  = m_crow * 4 + m_ccol;
    m_valid = 1'b1;
    m_down  = 1'b1;
    m_mode  = M_HELD;
  endtask

  task automatic finish_release();
    m_down = 1'b0;
    m_idx  = (m_idx + 1) % 4;
    m_cnt  = 0;
    m_mode = M_SCAN;
  endtask

  // One clock of the reference: acts on scan ticks only, strobe lasts one cycle.
  task automatic model_cycle();
    logic [3:0] sr;
    if (RST) begin
      m_div = 0; m_mode = M_SCAN; m_idx = 0; m_cnt = 0;
      m_code = 0; m_valid = 1'b0; m_down = 1'b0;
      return;
    end
    m_valid = 1'b0;
    if (m_div == SCAN_DIV - 1) begin
      sr = rows_seen(mask, m_idx);
      case (m_mode)
        M_SCAN: begin
          if (sr == 4'hF) m_idx = (m_idx + 1) % 4;
          else begin
            m_crow = 0;
            while (sr[m_crow]) m_crow++;
            m_ccol = m_idx;
            m_cnt  = 1;
            if (DT == 1) confirm_press(); else m_mode = M_DEB;
          end
        end
        M_DEB: begin
          if (!sr[m_crow]) begin
            if (m_cnt + 1 == DT) confirm_press();
            m_cnt++;
          end else begin
            m_cnt = 0; m_idx = (m_idx + 1) % 4; m_mode = M_SCAN;
          end
        end
        M_HELD: begin
          if (sr[m_crow]) begin
            if (DT == 1) finish_release();
            else begin m_cnt = 1; m_mode = M_REL; end
          end
        end
        default: begin
          if (sr[m_crow]) begin
            if (m_cnt + 1 == DT) finish_release(); else m_cnt++;
          end else begin
            m_cnt = 0; m_mode = M_HELD;
          end
        end
      endcase
      m_div = 0;
    end else begin
      m_div++;
    end
  endtask

  task automatic step();
    logic [3:0] exp_col;
    model_cycle();
    @(posedge CLK);
    #1;
    exp_col = ~(4'b0001 << m_idx);
    chk("col", 8'(kp.col), 8'(exp_col));
    chk("key_code", 8'(kp.key_code), 8'(m_code));
    chk("key_valid", 8'(kp.key_valid), 8'(m_valid));
    chk("key_down", 8'(kp.key_down), 8'(m_down));
    if (kp.key_valid === 1'b1) pulses++;
  endtask

  task automatic run_ticks(input int n, input logic [15:0] m);
    mask = m;
    for (int i = 0; i < n * SCAN_DIV; i++) step();
  endtask

  initial begin
    int p0;
    int k1, k2;
    vectors = 0; errors = 0; pulses = 0;
    mask = '0;
    RST  = 1'b1;
    step();
    step();
    chk("reset_col", 8'(kp.col), 8'h0E);
    chk("reset_code", 8'(kp.key_code), 8'h00);
    RST = 1'b0;

    // Idle scan across all columns and back to column 0.
    run_ticks(5, 16'h0000);
    chk("idle_valid_count", 8'(pulses), 8'd0);

    // Row 1 / column 2 held steady.
    run_ticks(6, 16'h0040);
    chk("s2_code", 8'(kp.key_code), 8'd6);
    chk("s2_down", 8'(kp.key_down), 8'd1);
    chk("s2_col", 8'(kp.col), 8'hB);
    chk("s2_pulses", 8'(pulses), 8'd1);

    // Clean release.
    run_ticks(5, 16'h0000);
    chk("s3_down", 8'(kp.key_down), 8'd0);
    chk("s3_pulses", 8'(pulses), 8'd1);

    // Same key (15) twice.
    p0 = pulses;
    run_ticks(8, 16'h8000);
    run_ticks(5, 16'h0000);
    run_ticks(8, 16'h8000);
    run_ticks(5, 16'h0000);
    chk("s4_pulses", 8'(pulses - p0), 8'd2);
    chk("s4_code", 8'(kp.key_code), 8'd15);

    // One-tick bounce on the column about to be scanned.
    p0 = pulses;
    run_ticks(1, 16'(1 << (8 + m_idx)));
    run_ticks(3, 16'h0000);
    chk("s5_pulses", 8'(pulses - p0), 8'd0);
    chk("s5_code", 8'(kp.key_code), 8'd15);

    // Rows 0 and 2 together in column 1; lowest row wins.
    run_ticks(8, 16'h0202);
    chk("s6_code", 8'(kp.key_code), 8'd1);
    chk("s6_down", 8'(kp.key_down), 8'd1);

    // Reset in the middle of a slot while held.
    step();
    step();
    mask = '0;
    RST  = 1'b1;
    step();
    chk("s6_rst_code", 8'(kp.key_code), 8'd0);
    chk("s6_rst_down", 8'(kp.key_down), 8'd0);
    chk("s6_rst_col", 8'(kp.col), 8'hE);
    RST = 1'b0;

    // Randomised key patterns.
    for (int it = 0; it < 40; it++) begin
      k1 = $urandom_range(15);
      k2 = $urandom_range(15);
      case ($urandom_range(2))
        0:       run_ticks($urandom_range(1, 6), 16'h0000);
        1:       run_ticks($urandom_range(1, 8), 16'(1 << k1));
        default: run_ticks($urandom_range(1, 8), 16'((1 << k1) | (1 << k2)));
      endcase
    end
    run_ticks(6, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
